// File: rtl/router_pkt_src_pkg.sv
// Shared definitions for the router packet source: header field widths,
// transmit state encoding and the header packing helper.
package router_pkt_src_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_e;

    // The header byte carries the payload length in the upper bits and the
    // destination port in the lower two bits.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_src_fifo.sv
// Payload byte buffer for the packet source: DEPTH x 8 synchronous FIFO with
// occupancy count, full flag and a registered overflow pulse.
module router_src_fifo #(
    parameter  int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [7:0]       wdata_i,
    input  logic             pop_i,
    output logic [7:0]       rdata_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             ovf_q;
    logic             push_ok;
    logic             pop_ok;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != '0);

    assign full_o  = (count_q == CNT_MAX);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Occupancy only moves when exactly one of push/pop takes effect.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH; overflow is flagged for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            ovf_q   <= push_i && full_o;
        end
    end

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for the router input port: buffers payload bytes and, on a
// start request, sends header -> payload -> parity while honouring busy, then
// waits a short gap watching the router's err flag.
module router_pkt_src
    import router_pkt_src_pkg::*;
#(
    parameter  int DEPTH      = 64,
    parameter  int GAP_CYCLES = 2,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  buf_count,
    output logic              buf_full,
    output logic              ovf,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              corrupt,
    output logic              start_rej,
    input  logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              pktvalid,
    output logic              tx_active,
    output logic              done,
    input  logic              err_in,
    output logic [7:0]        err_cnt
);

    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              pktvalid_q, pktvalid_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              corrupt_q, corrupt_d;
    logic [7:0]        gap_q, gap_d;
    logic              flag_q, flag_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] parity_next;

    router_src_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en),
        .wdata_i (wr_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (buf_count),
        .full_o  (buf_full),
        .ovf_o   (ovf)
    );

    assign dout      = dout_q;
    assign pktvalid  = pktvalid_q;
    assign tx_active = (state_q != IDLE);
    assign done      = done_q;
    assign start_rej = rej_q;
    assign err_cnt   = errcnt_q;

    // Parity covers header and every payload byte, including the one being consumed now.
    assign parity_next = acc_q ^ dout_q;

    // Next-state logic: each presented byte advances only on an edge with busy low.
    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        pktvalid_d = pktvalid_q;
        acc_d      = acc_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        corrupt_d  = corrupt_q;
        gap_d      = gap_q;
        flag_d     = flag_q;
        done_d     = 1'b0;
        rej_d      = 1'b0;
        errcnt_d   = errcnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((pkt_len != '0) && (buf_count >= CNT_W'(pkt_len))) begin
                        state_d    = HEADER;
                        len_d      = pkt_len;
                        corrupt_d  = corrupt;
                        dout_d     = make_header(pkt_len, dest_addr);
                        pktvalid_d = 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    state_d  = PAYLOAD;
                    acc_d    = dout_q;
                    cnt_d    = '0;
                    fifo_pop = 1'b1;
                    dout_d   = fifo_rdata;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    acc_d = parity_next;
                    if (cnt_q == (len_q - LEN_ONE)) begin
                        state_d    = PARITY;
                        pktvalid_d = 1'b0;
                        dout_d     = corrupt_q ? ~parity_next : parity_next;
                    end else begin
                        cnt_d    = cnt_q + LEN_ONE;
                        fifo_pop = 1'b1;
                        dout_d   = fifo_rdata;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    state_d = GAP;
                    dout_d  = '0;
                    gap_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            GAP: begin
                flag_d = flag_q | err_in;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if ((flag_q | err_in) && (errcnt_q != 8'hFF)) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                dout_d     = '0;
                pktvalid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears the byte lane immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dout_q     <= '0;
            pktvalid_q <= 1'b0;
            acc_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            corrupt_q  <= 1'b0;
            gap_q      <= '0;
            flag_q     <= 1'b0;
            done_q     <= 1'b0;
            rej_q      <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            pktvalid_q <= pktvalid_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            corrupt_q  <= corrupt_d;
            gap_q      <= gap_d;
            flag_q     <= flag_d;
            done_q     <= done_d;
            rej_q      <= rej_d;
            errcnt_q   <= errcnt_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// Testbench for router_pkt_src: a packet-level reference model (byte queue
// plus index into the packet being sent) checked every cycle, directed
// scenarios with hand-computed bytes, then a randomized soak.
module tb_router_pkt_src;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrEn = 1'b0;
    logic [7:0] wrData = '0;
    logic [6:0] bufCount;
    logic       bufFull;
    logic       ovf;
    logic       start = 1'b0;
    logic [1:0] destAddr = '0;
    logic [5:0] pktLen = '0;
    logic       corrupt = 1'b0;
    logic       startRej;
    logic       busy = 1'b0;
    logic [7:0] dout;
    logic       pktvalid;
    logic       txActive;
    logic       done;
    logic       errIn = 1'b0;
    logic [7:0] errCnt;

    int compared   = 0;
    int mismatched = 0;

    localparam int GAPC = 2;

    router_pkt_src #(.DEPTH(64), .GAP_CYCLES(GAPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wrEn),
        .wr_data   (wrData),
        .buf_count (bufCount),
        .buf_full  (bufFull),
        .ovf       (ovf),
        .start     (start),
        .dest_addr (destAddr),
        .pkt_len   (pktLen),
        .corrupt   (corrupt),
        .start_rej (startRej),
        .busy      (busy),
        .dout      (dout),
        .pktvalid  (pktvalid),
        .tx_active (txActive),
        .done      (done),
        .err_in    (errIn),
        .err_cnt   (errCnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: buffered bytes, and the packet as an index into
    // header(0) / payload(1..len) / parity(len+1).
    logic [7:0] mq[$];
    bit         mActive  = 0;
    int         mIdx     = 0;
    int         mLen     = 0;
    bit         mCorr    = 0;
    logic [7:0] mCur     = '0;
    logic [7:0] mPar     = '0;
    int         mGap     = 0;
    bit         mErrSeen = 0;
    int         mErrCnt  = 0;
    bit         mDone    = 0;
    bit         mRej     = 0;
    bit         mOvf     = 0;
    bit         mFullPre;

    // Advance the model on each clock edge using the inputs the DUT also samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mActive = 0; mIdx = 0; mGap = 0; mCur = '0; mPar = '0;
            mErrSeen = 0; mErrCnt = 0; mDone = 0; mRej = 0; mOvf = 0;
        end else begin
            mFullPre = (mq.size() == 64);
            mDone = 0; mRej = 0; mOvf = 0;
            if (mActive) begin
                if (!busy) begin
                    mPar = mPar ^ mCur;
                    mIdx++;
                    if (mIdx <= mLen) mCur = mq.pop_front();
                    else if (mIdx == mLen + 1) mCur = mCorr ? ~mPar : mPar;
                    else begin
                        mActive = 0; mCur = '0; mGap = GAPC; mErrSeen = 0;
                    end
                end
            end else if (mGap > 0) begin
                mErrSeen = mErrSeen | errIn;
                mGap--;
                if (mGap == 0) begin
                    mDone = 1;
                    if (mErrSeen && mErrCnt < 255) mErrCnt++;
                end
            end else if (start) begin
                if (pktLen != 0 && mq.size() >= int'(pktLen)) begin
                    mActive = 1; mIdx = 0; mLen = pktLen; mCorr = corrupt;
                    mPar = '0; mCur = {pktLen, destAddr};
                end else begin
                    mRej = 1;
                end
            end
            if (wrEn) begin
                if (mFullPre) mOvf = 1;
                else mq.push_back(wrData);
            end
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        checkOutput("dout", dout, mCur);
        checkOutput("pktvalid", pktvalid, (mActive && mIdx <= mLen) ? 1 : 0);
        checkOutput("tx_active", txActive, (mActive || mGap > 0) ? 1 : 0);
        checkOutput("done", done, mDone);
        checkOutput("start_rej", startRej, mRej);
        checkOutput("ovf", ovf, mOvf);
        checkOutput("buf_count", bufCount, mq.size());
        checkOutput("buf_full", bufFull, (mq.size() == 64) ? 1 : 0);
        checkOutput("err_cnt", errCnt, mErrCnt);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic writeByte(input logic [7:0] b);
        wrEn = 1'b1;
        wrData = b;
        cyc();
        wrEn = 1'b0;
    endtask

    // Pulse start for one cycle with the given packet parameters.
    task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len, input logic corr);
        start = 1'b1;
        destAddr = addr;
        pktLen = len;
        corrupt = corr;
        cyc();
        start = 1'b0;
        corrupt = 1'b0;
    endtask

    task automatic expectBeat(input string name, input logic [7:0] d, input logic pv);
        checkOutput({name, ".dout"}, dout, d);
        checkOutput({name, ".pktvalid"}, pktvalid, pv);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    initial begin
        resetDut();
        checkOutput("reset.buf_count", bufCount, 0);
        checkOutput("reset.tx_active", txActive, 0);

        // Basic packet: 11,22,33 to port 1.
        writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
        applyStimulus(2'd1, 6'd3, 1'b0);
        expectBeat("t1.hdr", 8'h0D, 1'b1);
        cyc(); expectBeat("t1.p0", 8'h11, 1'b1);
        cyc(); expectBeat("t1.p1", 8'h22, 1'b1);
        cyc(); expectBeat("t1.p2", 8'h33, 1'b1);
        cyc(); expectBeat("t1.par", 8'h0D, 1'b0);
        cyc(); expectBeat("t1.gap0", 8'h00, 1'b0);
        checkOutput("t1.gap0.tx_active", txActive, 1);
        cyc(); checkOutput("t1.gap1.done", done, 0);
        cyc(); checkOutput("t1.done", done, 1);
        checkOutput("t1.idle.tx_active", txActive, 0);

        // Back-pressure while 22 is on the lane.
        writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
        applyStimulus(2'd1, 6'd3, 1'b0);
        cyc(); cyc(); expectBeat("t2.p1", 8'h22, 1'b1);
        busy = 1'b1;
        cyc(); expectBeat("t2.hold0", 8'h22, 1'b1);
        cyc(); expectBeat("t2.hold1", 8'h22, 1'b1);
        busy = 1'b0;
        cyc(); expectBeat("t2.p2", 8'h33, 1'b1);
        cyc(); expectBeat("t2.par", 8'h0D, 1'b0);
        waitDone(10);

        // Corrupted parity with err during gap, then saturate the error counter.
        errIn = 1'b1;
        writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
        applyStimulus(2'd1, 6'd3, 1'b1);
        cyc(); cyc(); cyc();
        cyc(); expectBeat("t3.par", 8'hF2, 1'b0);
        waitDone(10);
        checkOutput("t3.err_cnt1", errCnt, 8'h01);
        for (int i = 0; i < 299; i++) begin
            writeByte(8'h11); writeByte(8'h22); writeByte(8'h33);
            applyStimulus(2'd1, 6'd3, 1'b1);
            waitDone(20);
        end
        checkOutput("t3.err_cnt_sat", errCnt, 8'hFF);
        errIn = 1'b0;

        // Refused starts.
        resetDut();
        writeByte(8'hA1); writeByte(8'hA2); writeByte(8'hA3);
        applyStimulus(2'd0, 6'd5, 1'b0);
        checkOutput("t4.rej_len5", startRej, 1);
        checkOutput("t4.tx_active", txActive, 0);
        cyc();
        checkOutput("t4.rej_clear", startRej, 0);
        applyStimulus(2'd0, 6'd0, 1'b0);
        checkOutput("t4.rej_len0", startRej, 1);
        checkOutput("t4.buf_count", bufCount, 3);

        // Overflow and a full-length packet.
        resetDut();
        wrEn = 1'b1;
        for (int i = 0; i < 65; i++) begin
            wrData = 8'(i);
            cyc();
            if (i == 63) begin
                checkOutput("t5.count64", bufCount, 64);
                checkOutput("t5.no_ovf", ovf, 0);
            end
        end
        wrEn = 1'b0;
        checkOutput("t5.ovf", ovf, 1);
        checkOutput("t5.full", bufFull, 1);
        checkOutput("t5.count_after", bufCount, 64);
        applyStimulus(2'd0, 6'd63, 1'b0);
        expectBeat("t5.hdr", 8'hFC, 1'b1);
        waitDone(100);
        checkOutput("t5.count1", bufCount, 1);
        applyStimulus(2'd2, 6'd1, 1'b0);
        checkOutput("t5.len1_active", txActive, 1);
        waitDone(20);
        checkOutput("t5.count0", bufCount, 0);

        // Asynchronous reset in the middle of the payload.
        resetDut();
        for (int i = 0; i < 10; i++) writeByte(8'h40 + 8'(i));
        applyStimulus(2'd3, 6'd8, 1'b0);
        cyc(); cyc(); cyc();
        expectBeat("t6.mid", 8'h42, 1'b1);
        #1 rst = 1'b1;
        #1;
        expectBeat("t6.async", 8'h00, 1'b0);
        checkOutput("t6.buf_count", bufCount, 0);
        #2 rst = 1'b0;
        cyc();
        checkOutput("t6.idle", txActive, 0);

        // Randomized soak against the model.
        for (int i = 0; i < 4000; i++) begin
            wrEn     = ($urandom_range(0, 9) < 7);
            wrData   = 8'($urandom);
            busy     = ($urandom_range(0, 9) < 3);
            errIn    = ($urandom_range(0, 9) < 2);
            start    = ($urandom_range(0, 9) == 0);
            destAddr = 2'($urandom);
            pktLen   = 6'($urandom_range(0, 20));
            corrupt  = 1'($urandom);
            cyc();
        end
        wrEn = 1'b0; busy = 1'b0; errIn = 1'b0; start = 1'b0;
        repeat (100) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
